// File: rtl/vga_dbuf_if.sv
// Renderer-side write/swap channel of the double-buffered VGA engine.
// The renderer drives master; vga_dbuf_scaler takes slave.
interface vga_dbuf_if #(
  parameter int COLOUR_W = 4
) ();
  logic                wr_valid;
  logic                wr_ready;
  logic [9:0]          wr_x;
  logic [9:0]          wr_y;
  logic [COLOUR_W-1:0] wr_colour;
  logic                swap_req;
  logic                swap_ack;
  logic                front_sel;
  logic                frame_start;

  modport master (
    output wr_valid, wr_x, wr_y, wr_colour, swap_req,
    input  wr_ready, swap_ack, front_sel, frame_start
  );
  modport slave (
    input  wr_valid, wr_x, wr_y, wr_colour, swap_req,
    output wr_ready, swap_ack, front_sel, frame_start
  );
endinterface

// File: rtl/vga_dbuf_scaler.sv
// Double-buffered VGA scan-out with integer pixel replication and frame-boundary swap.
// Define VGA_DBUF_CLEAR_EN to auto-clear the back buffer after reset and after each swap.
module vga_dbuf_scaler #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 1,
  parameter int COLOUR_W    = 4,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic       clk_25M,
  input  logic       rst_n,
  vga_dbuf_if.slave  bus,
  output logic       hs,
  output logic       vs,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int FB_W    = H_VISIBLE >> SCALE_SHIFT;
  localparam int FB_H    = V_VISIBLE >> SCALE_SHIFT;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int AW      = $clog2(FB_SIZE);

  localparam logic [HW-1:0] H_ACT0 = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT1 = HW'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC);
  localparam logic [VW-1:0] V_ACT0 = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT1 = VW'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC);
  localparam logic [9:0]    FB_W_L = 10'(FB_W);
  localparam logic [9:0]    FB_H_L = 10'(FB_H);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } tim_t;
  localparam tim_t TIM_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic [HW-1:0]       cnt_h_q, cnt_h_d, ox;
  logic [VW-1:0]       cnt_v_q, cnt_v_d, oy;
  logic                h_wrap, frame_end, swap_now, in_range, clearing, wr_ready;
  logic                front_sel_q, front_sel_d, swap_ack_q, swap_ack_d;
  tim_t                tim0;
  tim_t [2:1]          tim_pipe_q, tim_pipe_d;
  logic [AW-1:0]       scan_addr, wr_addr, clr_addr, mem_addr;
  logic                mem_we;
  logic [COLOUR_W-1:0] mem_data, rd_data_q;
  logic [11:0]         colour_rgb, rgb_q, rgb_d;
  logic [COLOUR_W-1:0] fb0 [FB_SIZE];
  logic [COLOUR_W-1:0] fb1 [FB_SIZE];

  always_comb begin
    h_wrap    = (cnt_h_q == H_LAST);
    frame_end = h_wrap && (cnt_v_q == V_LAST);
    cnt_h_d   = h_wrap ? '0 : cnt_h_q + 1'b1;
    cnt_v_d   = cnt_v_q;
    if (h_wrap) cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 1'b1;

    tim0.act  = (cnt_h_q >= H_ACT0) && (cnt_h_q < H_ACT1) &&
                (cnt_v_q >= V_ACT0) && (cnt_v_q < V_ACT1);
    tim0.hs   = (cnt_h_q >= H_SE);
    tim0.vs   = (cnt_v_q >= V_SE);
    tim0.fs   = (cnt_h_q == '0) && (cnt_v_q == '0);
    ox        = cnt_h_q - H_ACT0;
    oy        = cnt_v_q - V_ACT0;
    // Park the read address at 0 while blanked so it never leaves the array.
    scan_addr = tim0.act ? AW'((32'(oy) >> SCALE_SHIFT) * FB_W + (32'(ox) >> SCALE_SHIFT)) : '0;
    tim_pipe_d = {tim_pipe_q[1], tim0};

    in_range    = (bus.wr_x < FB_W_L) && (bus.wr_y < FB_H_L);
    wr_addr     = AW'(32'(bus.wr_y) * FB_W + 32'(bus.wr_x));
    swap_now    = frame_end && bus.swap_req && !clearing;
    front_sel_d = front_sel_q ^ swap_now;
    swap_ack_d  = swap_now;

    mem_we   = clearing || (bus.wr_valid && in_range);
    mem_addr = clearing ? clr_addr : wr_addr;
    mem_data = clearing ? CLEAR_COLOUR : bus.wr_colour;
    rgb_d    = tim_pipe_q[1].act ? colour_rgb : 12'h000;
  end

`ifdef VGA_DBUF_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_SIZE - 1);
  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_IDLE: if (swap_now) begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clearing = (state_q == S_CLEAR);
    wr_ready = (state_q == S_IDLE);
    clr_addr = clr_addr_q;
  end
`else
  assign clearing = 1'b0;
  assign wr_ready = 1'b1;
  assign clr_addr = '0;
`endif

  // Writes go to the buffer not being scanned; the read side is the front one.
  always_ff @(posedge clk_25M) begin
    if (mem_we && front_sel_q)  fb0[mem_addr] <= mem_data;
    if (mem_we && !front_sel_q) fb1[mem_addr] <= mem_data;
    rd_data_q <= front_sel_q ? fb1[scan_addr] : fb0[scan_addr];
  end

  generate
    if (COLOUR_W == 4) begin : g_pal
      always_comb begin
        colour_rgb = 12'h000;
        case (rd_data_q)
          4'd0:  colour_rgb = 12'h000;
          4'd1:  colour_rgb = 12'hFFF;
          4'd2:  colour_rgb = 12'h000;
          4'd3:  colour_rgb = 12'hFEA;
          4'd4:  colour_rgb = 12'hFF0;
          4'd5:  colour_rgb = 12'h0AF;
          4'd6:  colour_rgb = 12'h34C;
          4'd7:  colour_rgb = 12'hCF0;
          4'd8:  colour_rgb = 12'h0D4;
          4'd9:  colour_rgb = 12'hB75;
          4'd10: colour_rgb = 12'h743;
          4'd11: colour_rgb = 12'hCCC;
          4'd12: colour_rgb = 12'h555;
          4'd13: colour_rgb = 12'hF00;
          4'd14: colour_rgb = 12'hF72;
          4'd15: colour_rgb = 12'hABC;
          default: colour_rgb = 12'h000;
        endcase
      end
    end else begin : g_rgb
      assign colour_rgb = rd_data_q[11:0];
    end
  endgenerate

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h_q     <= '0;
      cnt_v_q     <= '0;
      tim_pipe_q  <= {TIM_IDLE, TIM_IDLE};
      rgb_q       <= '0;
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      cnt_h_q     <= cnt_h_d;
      cnt_v_q     <= cnt_v_d;
      tim_pipe_q  <= tim_pipe_d;
      rgb_q       <= rgb_d;
      front_sel_q <= front_sel_d;
      swap_ack_q  <= swap_ack_d;
    end
  end

  assign hs              = tim_pipe_q[2].hs;
  assign vs              = tim_pipe_q[2].vs;
  assign {red, green, blue} = rgb_q;
  assign bus.wr_ready    = wr_ready;
  assign bus.swap_ack    = swap_ack_q;
  assign bus.front_sel   = front_sel_q;
  assign bus.frame_start = tim_pipe_q[2].fs;
endmodule

// File: tb/tb_vga_dbuf_scaler.sv
// Directed bench: a reduced-timing palette instance (A) and a tiny RGB444 instance (B).
// Output at cycle n+2 reflects counter position n; cycle 0 is the first cycle after reset release.
module tb_vga_dbuf_scaler;
`ifdef VGA_DBUF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk_25M = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;

  always #20 clk_25M = ~clk_25M;
  always @(posedge clk_25M or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  vga_dbuf_if #(.COLOUR_W(4))  ifa ();
  vga_dbuf_if #(.COLOUR_W(12)) ifb ();
  logic        hs_a, vs_a, hs_b, vs_b;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic [31:0] rgb_a, rgb_b;
  assign rgb_a = {20'd0, red_a, green_a, blue_a};
  assign rgb_b = {20'd0, red_b, green_b, blue_b};

  // A: HT=23 (sync 3, back 2, vis 16, front 2), VT=12 (2,1,8,1), FB 8x4.
  vga_dbuf_scaler #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SCALE_SHIFT(1), .COLOUR_W(4), .CLEAR_COLOUR(4'd0)
  ) dut_a (
    .clk_25M(clk_25M), .rst_n(rst_n), .bus(ifa.slave),
    .hs(hs_a), .vs(vs_a), .red(red_a), .green(green_a), .blue(blue_a)
  );

  // B: HT=12 (2,1,8,1), VT=7 (1,1,4,1), FB 8x4, direct RGB.
  vga_dbuf_scaler #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SCALE_SHIFT(0), .COLOUR_W(12), .CLEAR_COLOUR(12'h000)
  ) dut_b (
    .clk_25M(clk_25M), .rst_n(rst_n), .bus(ifb.slave),
    .hs(hs_b), .vs(vs_b), .red(red_b), .green(green_b), .blue(blue_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk_25M);
  endtask

  task automatic wr_a(input int x, input int y, input logic [3:0] c);
    int n = 0;
    ifa.wr_x = 10'(x); ifa.wr_y = 10'(y); ifa.wr_colour = c; ifa.wr_valid = 1'b1;
    while (!ifa.wr_ready && n < 200) begin @(negedge clk_25M); n++; end
    if (!ifa.wr_ready) begin
      total++; bad++;
      $error("FAIL wr_a_timeout: got ready=0 want ready=1 within 200 cycles");
    end
    @(negedge clk_25M);
    ifa.wr_valid = 1'b0;
  endtask

  task automatic wr_b(input int x, input int y, input logic [11:0] c);
    int n = 0;
    ifb.wr_x = 10'(x); ifb.wr_y = 10'(y); ifb.wr_colour = c; ifb.wr_valid = 1'b1;
    while (!ifb.wr_ready && n < 200) begin @(negedge clk_25M); n++; end
    if (!ifb.wr_ready) begin
      total++; bad++;
      $error("FAIL wr_b_timeout: got ready=0 want ready=1 within 200 cycles");
    end
    @(negedge clk_25M);
    ifb.wr_valid = 1'b0;
  endtask

  initial begin
    ifa.wr_valid = 1'b0; ifa.wr_x = '0; ifa.wr_y = '0; ifa.wr_colour = '0; ifa.swap_req = 1'b0;
    ifb.wr_valid = 1'b0; ifb.wr_x = '0; ifb.wr_y = '0; ifb.wr_colour = '0; ifb.swap_req = 1'b0;
    repeat (3) @(negedge clk_25M);
    rst_n = 1'b1;

    // reset state (cycle 0) and 2-cycle output latency
    chk("rst_hs", 32'(hs_a), 32'd1);
    chk("rst_vs", 32'(vs_a), 32'd1);
    chk("rst_rgb_a", rgb_a, 32'h000);
    chk("rst_rgb_b", rgb_b, 32'h000);
    chk("rst_ack", 32'(ifa.swap_ack), 32'd0);
    chk("rst_fs", 32'(ifa.frame_start), 32'd0);
    chk("rst_front", 32'(ifa.front_sel), 32'd0);
    chk("rst_ready", 32'(ifa.wr_ready), CLR ? 32'd0 : 32'd1);
    at(1);  chk("c1_rgb", rgb_a, 32'h000);   chk("c1_hs", 32'(hs_a), 32'd1);
    at(2);  chk("c2_fs", 32'(ifa.frame_start), 32'd1);
            chk("c2_hs", 32'(hs_a), 32'd0);  chk("c2_vs", 32'(vs_a), 32'd0);
    at(4);  chk("hs_low_end", 32'(hs_a), 32'd0);
    at(5);  chk("hs_rise", 32'(hs_a), 32'd1);
    at(6);  chk("fs_pulse_end", 32'(ifa.frame_start), 32'd0);
    at(25); chk("hs_period", 32'(hs_a), 32'd0);
    at(47); chk("vs_low_end", 32'(vs_a), 32'd0);
    at(48); chk("vs_rise", 32'(vs_a), 32'd1);

    // B: two pixels at the corners of its visible area, then swap
    at(49);
    wr_b(7, 3, 12'h123);
    wr_b(0, 0, 12'hABC);
    ifb.swap_req = 1'b1;
    // A: fill back buffer (1) with index 11
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) wr_a(x, y, 4'd11);
    at(83); chk("b_ack_early", 32'(ifb.swap_ack), 32'd0);
    at(84); chk("b_ack", 32'(ifb.swap_ack), 32'd1);
            chk("b_front", 32'(ifb.front_sel), 32'd1);
    ifb.swap_req = 1'b0;
    at(85); chk("b_ack_once", 32'(ifb.swap_ack), 32'd0);

    at(100); ifa.swap_req = 1'b1;
    at(113); chk("b_first_px", rgb_b, 32'hABC);
    at(156); chk("b_last_px", rgb_b, 32'h123);
    at(157); chk("b_blank_after", rgb_b, 32'h000);

    // A swap #1 only at frame end
    at(275); chk("a_ack_early", 32'(ifa.swap_ack), 32'd0);
             chk("a_front_early", 32'(ifa.front_sel), 32'd0);
    at(276); chk("a_ack1", 32'(ifa.swap_ack), 32'd1);
             chk("a_front1", 32'(ifa.front_sel), 32'd1);
    ifa.swap_req = 1'b0;
    at(277); chk("a_ack1_once", 32'(ifa.swap_ack), 32'd0);
             chk("a_ready_post_swap", 32'(ifa.wr_ready), CLR ? 32'd0 : 32'd1);
    at(278); chk("fs_frame1", 32'(ifa.frame_start), 32'd1);
             chk("vs_frame1", 32'(vs_a), 32'd0);
`ifdef VGA_DBUF_CLEAR_EN
    at(307); chk("clr_last_cycle", 32'(ifa.wr_ready), 32'd0);
    at(308); chk("clr_done", 32'(ifa.wr_ready), 32'd1);
`endif
    at(351); chk("f1_blank_left", rgb_a, 32'h000);
    at(352); chk("f1_first_px", rgb_a, 32'hCCC);
    at(368); chk("f1_blank_right", rgb_a, 32'h000);

    // A: fill buffer 0 with 12, then a pixel, two out-of-range writes, last pixel
    at(370);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) wr_a(x, y, 4'd12);
    wr_a(3, 2, 4'd5);
    wr_a(8, 1, 4'd13);
    wr_a(0, 4, 4'd13);
    wr_a(7, 3, 4'd13);
    at(420); ifa.swap_req = 1'b1;

    // write on the swap cycle lands in the old back buffer (0)
    at(551); chk("a_ack2_early", 32'(ifa.swap_ack), 32'd0);
    wr_a(0, 0, 4'd7);
    chk("a_ack2", 32'(ifa.swap_ack), 32'd1);
    chk("a_front2", 32'(ifa.front_sel), 32'd0);
    at(553); chk("a_ack2_once", 32'(ifa.swap_ack), 32'd0);
    at(628); chk("f2_swapcycle_wr", rgb_a, 32'hCF0);
    at(720); chk("f2_dropped_x", rgb_a, 32'h555);
    at(726); chk("f2_px_3_2", rgb_a, 32'h0AF);
    at(728); chk("f2_neighbour", rgb_a, 32'h555);
    at(750); chk("f2_px_3_2_repl", rgb_a, 32'h0AF);
    at(804); chk("f2_last_px", rgb_a, 32'hF00);
    at(805); chk("f2_after_last", rgb_a, 32'h000);

    // held request: second consecutive swap
    at(827); chk("a_ack3_early", 32'(ifa.swap_ack), 32'd0);
    at(828); chk("a_ack3", 32'(ifa.swap_ack), 32'd1);
             chk("a_front3", 32'(ifa.front_sel), 32'd1);
    ifa.swap_req = 1'b0;
    at(830);  chk("fs_frame3", 32'(ifa.frame_start), 32'd1);
    at(904);  chk("f3_buf1_px", rgb_a, CLR ? 32'h000 : 32'hCCC);
    at(1104); chk("no_ack_idle", 32'(ifa.swap_ack), 32'd0);
              chk("front_hold", 32'(ifa.front_sel), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
